// File: rtl/pll_lock_seq.sv
// PLL start-up/lock sequencer: drives PLL reset, qualifies lock, switches clock mux, releases sys_rst.
// Latency: outputs are a pure decode of the registered state, so every reaction lands one refclk edge after its cause.
// Backpressure: none; level inputs sampled every cycle, relock_req is a single-cycle pulse.
module pll_lock_seq #(
  parameter int unsigned RST_CYCLES    = 16,
  parameter int unsigned LOCK_CYCLES   = 256,
  parameter int unsigned STABLE_CYCLES = 32,
  parameter int unsigned SWITCH_CYCLES = 4,
  parameter int unsigned MAX_RETRY     = 3,
  parameter int unsigned CW            = 16
) (
  input  logic       refclk,
  input  logic       reset,
  input  logic       pll_lock,
  input  logic       test_mode,
  input  logic       relock_req,
  output logic       pll_reset,
  output logic       clk_sel,
  output logic       sys_rst,
  output logic       pll_ready,
  output logic       lock_err,
  output logic [2:0] state,
  output logic [1:0] retry_cnt
);

  typedef enum logic [2:0] {
    RESET_PLL = 3'd0,
    WAIT_LOCK = 3'd1,
    SETTLE    = 3'd2,
    SWITCH    = 3'd3,
    RUN       = 3'd4,
    ERROR     = 3'd5,
    BYPASS    = 3'd6
  } state_t;

  localparam logic [CW-1:0] RST_LAST    = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] LOCK_LAST   = CW'(LOCK_CYCLES - 1);
  localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] SWITCH_LAST = CW'(SWITCH_CYCLES - 1);
  localparam logic [1:0]    RETRY_MAX   = 2'(MAX_RETRY);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    retry_q, retry_d;
  logic [1:0]    retry_inc;

  // State, shared cycle counter and retry count registers.
  always_ff @(posedge refclk) begin
    if (reset) begin
      state_q <= RESET_PLL;
      cnt_q   <= '0;
      retry_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      retry_q <= retry_d;
    end
  end

  // Next state: test_mode beats relock_req, which beats the per-state rules.
  always_comb begin
    state_d   = state_q;
    retry_d   = retry_q;
    // Saturating increment; only used on a lock-wait timeout.
    retry_inc = (retry_q == RETRY_MAX) ? retry_q : retry_q + 2'd1;

    if (test_mode) begin
      state_d = BYPASS;
    end else if (relock_req && (state_q == RUN || state_q == ERROR)) begin
      state_d = RESET_PLL;
      retry_d = '0;
    end else begin
      unique case (state_q)
        RESET_PLL: if (cnt_q == RST_LAST) state_d = WAIT_LOCK;
        WAIT_LOCK: begin
          if (pll_lock) begin
            state_d = SETTLE;
          end else if (cnt_q == LOCK_LAST) begin
            retry_d = retry_inc;
            state_d = (retry_inc == RETRY_MAX) ? ERROR : RESET_PLL;
          end
        end
        // Any lock glitch restarts both the stability and timeout windows.
        SETTLE: begin
          if (!pll_lock)                   state_d = WAIT_LOCK;
          else if (cnt_q == STABLE_LAST)   state_d = SWITCH;
        end
        // Lock is deliberately ignored here: the mux is mid-switch under reset.
        SWITCH: begin
          if (cnt_q == SWITCH_LAST) begin
            state_d = RUN;
            retry_d = '0;
          end
        end
        RUN:     if (!pll_lock) state_d = RESET_PLL;
        ERROR:   state_d = ERROR;
        BYPASS: begin
          state_d = RESET_PLL;
          retry_d = '0;
        end
        default: state_d = RESET_PLL;
      endcase
    end

    // Counter restarts on every state change, otherwise free-runs.
    cnt_d = (state_d != state_q) ? '0 : cnt_q + CW'(1);
  end

  // Moore output decode from the registered state only.
  always_comb begin
    pll_reset = 1'b0;
    clk_sel   = 1'b0;
    sys_rst   = 1'b1;
    pll_ready = 1'b0;
    lock_err  = 1'b0;
    unique case (state_q)
      RESET_PLL: pll_reset = 1'b1;
      WAIT_LOCK: ;
      SETTLE:    ;
      SWITCH:    clk_sel = 1'b1;
      RUN: begin
        clk_sel   = 1'b1;
        sys_rst   = 1'b0;
        pll_ready = 1'b1;
      end
      ERROR: begin
        pll_reset = 1'b1;
        sys_rst   = 1'b0;
        lock_err  = 1'b1;
      end
      BYPASS: begin
        pll_reset = 1'b1;
        sys_rst   = 1'b0;
      end
      default: pll_reset = 1'b1;
    endcase
  end

  assign state     = state_q;
  assign retry_cnt = retry_q;

endmodule

// File: tb/tb_pll_lock_seq.sv
// Directed bench for pll_lock_seq with default parameters.
// Inputs change and outputs are sampled 1 time unit after each rising refclk edge.
// Expected values are hand-derived edge counts from the sequencer timing.
module tb_pll_lock_seq;

  logic       refclk = 1'b0;
  logic       reset;
  logic       pll_lock;
  logic       test_mode;
  logic       relock_req;
  logic       pll_reset;
  logic       clk_sel;
  logic       sys_rst;
  logic       pll_ready;
  logic       lock_err;
  logic [2:0] state;
  logic [1:0] retry_cnt;

  int checks   = 0;
  int failures = 0;

  pll_lock_seq dut (
    .refclk     (refclk),
    .reset      (reset),
    .pll_lock   (pll_lock),
    .test_mode  (test_mode),
    .relock_req (relock_req),
    .pll_reset  (pll_reset),
    .clk_sel    (clk_sel),
    .sys_rst    (sys_rst),
    .pll_ready  (pll_ready),
    .lock_err   (lock_err),
    .state      (state),
    .retry_cnt  (retry_cnt)
  );

  always #5 refclk = ~refclk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge refclk);
    #1;
  endtask

  // Compare all five decoded outputs in one go.
  task automatic check_outs(input string tag, input logic [4:0] exp);
    check({tag, ".outs"}, int'({pll_reset, clk_sel, sys_rst, pll_ready, lock_err}), int'(exp));
  endtask

  initial begin
    reset = 1'b1; pll_lock = 1'b1; test_mode = 1'b0; relock_req = 1'b0;
    tick(3);
    check("rst.state", state, 0);
    check("rst.retry", retry_cnt, 0);
    check_outs("rst", 5'b10100);

    // Clean lock: edges counted from reset release.
    reset = 1'b0;
    tick(15);
    check("clean.e15.state", state, 0);
    check("clean.e15.pll_reset", pll_reset, 1);
    tick(1);
    check("clean.e16.state", state, 1);
    check("clean.e16.pll_reset", pll_reset, 0);
    tick(1);
    check("clean.e17.state", state, 2);
    tick(31);
    check("clean.e48.state", state, 2);
    tick(1);
    check("clean.e49.state", state, 3);
    check_outs("clean.e49", 5'b01100);
    tick(3);
    check("clean.e52.state", state, 3);
    tick(1);
    check("clean.e53.state", state, 4);
    check_outs("clean.e53", 5'b01010);

    // Lock loss in RUN, then recovery 53 edges later.
    pll_lock = 1'b0;
    tick(1);
    check("loss.state", state, 0);
    check_outs("loss", 5'b10100);
    pll_lock = 1'b1;
    tick(52);
    check("loss.e52.state", state, 3);
    tick(1);
    check("loss.e53.state", state, 4);

    // relock_req together with a lock drop in RUN.
    pll_lock = 1'b0; relock_req = 1'b1;
    tick(1);
    check("relock_drop.state", state, 0);
    check("relock_drop.retry", retry_cnt, 0);
    pll_lock = 1'b1; relock_req = 1'b0;

    // relock_req in SETTLE is ignored; then lock chatter at cnt 20.
    tick(17);
    check("chat.settle", state, 2);
    relock_req = 1'b1;
    tick(1);
    check("chat.relock_ignored", state, 2);
    relock_req = 1'b0;
    tick(19);
    check("chat.cnt20", state, 2);
    pll_lock = 1'b0;
    tick(1);
    check("chat.drop", state, 1);
    pll_lock = 1'b1;
    tick(1);
    check("chat.resettle", state, 2);
    tick(31);
    check("chat.still_settle", state, 2);
    tick(1);
    check("chat.switch", state, 3);
    tick(4);
    check("chat.run", state, 4);

    // Reset beats test_mode and relock_req.
    reset = 1'b1; test_mode = 1'b1; relock_req = 1'b1;
    tick(1);
    check("prio.state", state, 0);
    check_outs("prio", 5'b10100);
    reset = 1'b0; test_mode = 1'b0; relock_req = 1'b0;

    // One timeout with no lock.
    pll_lock = 1'b0;
    tick(271);
    check("to1.e271.state", state, 1);
    check("to1.e271.retry", retry_cnt, 0);
    tick(1);
    check("to1.e272.state", state, 0);
    check("to1.e272.retry", retry_cnt, 1);

    // DFT bypass from WAIT_LOCK clears the retry count on exit.
    tick(16);
    check("dft.wait", state, 1);
    test_mode = 1'b1;
    tick(1);
    check("dft.bypass", state, 6);
    check_outs("dft.bypass", 5'b10000);
    tick(5);
    check("dft.hold", state, 6);
    check("dft.hold.retry", retry_cnt, 1);
    test_mode = 1'b0;
    tick(1);
    check("dft.exit.state", state, 0);
    check("dft.exit.retry", retry_cnt, 0);

    // Three timeouts into ERROR.
    tick(544);
    check("to.e544.retry", retry_cnt, 2);
    tick(271);
    check("to.e815.state", state, 1);
    tick(1);
    check("to.e816.state", state, 5);
    check("to.e816.retry", retry_cnt, 3);
    check_outs("to.e816", 5'b10001);
    tick(20);
    check("err.hold", state, 5);
    relock_req = 1'b1;
    tick(1);
    relock_req = 1'b0;
    check("err.relock.state", state, 0);
    check("err.relock.retry", retry_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
